// File: rtl/alu_muldiv_if.sv
// Request/response bundle between operand fetch, the execute ALU and writeback.
// Signal names keep the i/o direction letters as seen from the ALU.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            iValid;
  logic            oReady;
  logic [4:0]      iOp;
  logic [XLEN-1:0] iOpA;
  logic [XLEN-1:0] iOpB;
  logic [4:0]      iTag;
  logic            oValid;
  logic [XLEN-1:0] oResult;
  logic [4:0]      oTag;
  logic            oIllegal;

  // Issuing side (decode / operand fetch, or a bench)
  modport master (
    output iValid, iOp, iOpA, iOpB, iTag,
    input  oReady, oValid, oResult, oTag, oIllegal
  );

  // Execute side (the ALU)
  modport slave (
    input  iValid, iOp, iOpA, iOpB, iTag,
    output oReady, oValid, oResult, oTag, oIllegal
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle RV32I/RV64I register-register ops plus
// iterative M-extension multiply (shift-add) and divide (restoring).
// One op in flight; every accepted op returns exactly one tagged strobe.
module alu_muldiv #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic        iClk,
  input  logic        iRst,
  alu_muldiv_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi;       // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;       // multiplier bits / quotient bits
  logic [XLEN-1:0]   r_b;        // multiplicand / divisor magnitude
  logic              r_neg;      // negate the selected result at completion
  logic              r_sel;      // 1: high product half or remainder
  logic [4:0]        r_tag_lat;

  logic              r_valid;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_tag;
  logic              r_illegal;

  logic              w_ready;
  logic              w_busy_mul;
  logic              w_busy_div;
  logic              w_last;
  logic              w_done;
  logic              w_accept;

  logic              w_is_alu;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_legal;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_sel;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_start_neg;
  logic              w_div_zero;
  logic              w_div_ovf;
  logic              w_div_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_start_mul;
  logic              w_start_div;
  logic              w_single;

  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu_res;
  logic [XLEN-1:0]   w_single_res;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_sh;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_diff;

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_div_raw;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_done_res;

  // Opcode decode: legality, operand signedness and result half/remainder select
  always_comb begin
    w_is_alu   = 1'b0;
    w_is_mul   = 1'b0;
    w_is_div   = 1'b0;
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    w_sel      = 1'b0;
    case (bus.iOp)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: w_is_alu = 1'b1;
      OP_MUL: begin
        w_is_mul   = MUL_EN;
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_MULH: begin
        w_is_mul   = MUL_EN;
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
        w_sel      = 1'b1;
      end
      OP_MULHSU: begin
        w_is_mul   = MUL_EN;
        w_a_signed = 1'b1;
        w_sel      = 1'b1;
      end
      OP_MULHU: begin
        w_is_mul   = MUL_EN;
        w_sel      = 1'b1;
      end
      OP_DIV: begin
        w_is_div   = DIV_EN;
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_DIVU: begin
        w_is_div   = DIV_EN;
      end
      OP_REM: begin
        w_is_div   = DIV_EN;
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
        w_sel      = 1'b1;
      end
      OP_REMU: begin
        w_is_div   = DIV_EN;
        w_sel      = 1'b1;
      end
      default: w_is_alu = 1'b0;
    endcase
  end

  assign w_legal = w_is_alu | w_is_mul | w_is_div;

  // Magnitudes feed the iterative engine; the sign is restored at completion.
  // For remainders the sign follows the dividend only.
  assign w_a_neg     = w_a_signed & bus.iOpA[XLEN-1];
  assign w_b_neg     = w_b_signed & bus.iOpB[XLEN-1];
  assign w_a_mag     = w_a_neg ? -bus.iOpA : bus.iOpA;
  assign w_b_mag     = w_b_neg ? -bus.iOpB : bus.iOpB;
  assign w_start_neg = (w_is_div & w_sel) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // Divide by zero and the single signed-overflow case finish without iterating
  assign w_div_zero    = (bus.iOpB == ZERO);
  assign w_div_ovf     = w_a_signed & (bus.iOpA == MIN_NEG) & (bus.iOpB == ALL_ONES);
  assign w_div_special = w_is_div & (w_div_zero | w_div_ovf);
  assign w_special_res = w_div_zero ? (w_sel ? bus.iOpA : ALL_ONES)
                                    : (w_sel ? ZERO : bus.iOpA);

  assign w_accept    = bus.iValid & w_ready;
  assign w_start_mul = w_accept & w_is_mul;
  assign w_start_div = w_accept & w_is_div & ~w_div_special;
  assign w_single    = w_accept & ~w_start_mul & ~w_start_div;

  assign w_shamt = bus.iOpB[SHW-1:0];

  // Single-cycle integer operations
  always_comb begin
    w_alu_res = ZERO;
    case (bus.iOp)
      OP_ADD:  w_alu_res = bus.iOpA + bus.iOpB;
      OP_SUB:  w_alu_res = bus.iOpA - bus.iOpB;
      OP_SLL:  w_alu_res = bus.iOpA << w_shamt;
      OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.iOpA) < $signed(bus.iOpB))};
      OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (bus.iOpA < bus.iOpB)};
      OP_XOR:  w_alu_res = bus.iOpA ^ bus.iOpB;
      OP_SRL:  w_alu_res = bus.iOpA >> w_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(bus.iOpA) >>> w_shamt);
      OP_OR:   w_alu_res = bus.iOpA | bus.iOpB;
      OP_AND:  w_alu_res = bus.iOpA & bus.iOpB;
      default: w_alu_res = ZERO;
    endcase
  end

  assign w_single_res = !w_legal ? ZERO : (w_is_div ? w_special_res : w_alu_res);

  // One shift-add step: conditionally add multiplicand to the high half, then
  // shift {carry, hi, lo} right so the next multiplier bit lands in lo[0].
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});

  // One restoring step: bring the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The difference is below the divisor,
  // so XLEN bits hold it exactly.
  assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
  assign w_div_diff = w_div_sh[XLEN-1:0] - r_b;

  // Completion sign fixup
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_mul_res  = r_sel ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
  assign w_div_raw  = r_sel ? r_hi : r_lo;
  assign w_div_res  = r_neg ? -w_div_raw : w_div_raw;
  assign w_done_res = w_busy_mul ? w_mul_res : w_div_res;

  assign w_last = (r_cnt == CNT_LAST);
  assign w_done = (w_busy_mul | w_busy_div) & w_last;

  // FSM state register
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: multi-cycle ops leave IDLE, XLEN iterations plus a finish edge bring it back
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_mul) begin
          w_state_nxt = ST_MUL;
        end else if (w_start_div) begin
          w_state_nxt = ST_DIV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE, busy flags select the iteration kind
  always_comb begin
    w_ready    = 1'b0;
    w_busy_mul = 1'b0;
    w_busy_div = 1'b0;
    case (r_state)
      ST_IDLE: w_ready    = 1'b1;
      ST_MUL:  w_busy_mul = 1'b1;
      ST_DIV:  w_busy_div = 1'b1;
      default: w_ready    = 1'b0;
    endcase
  end

  // Iterative engine: latch operands on start, step once per cycle until the counter hits XLEN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_cnt     <= CNT_ZERO;
      r_hi      <= ZERO;
      r_lo      <= ZERO;
      r_b       <= ZERO;
      r_neg     <= 1'b0;
      r_sel     <= 1'b0;
      r_tag_lat <= 5'd0;
    end else if (w_start_mul || w_start_div) begin
      r_cnt     <= CNT_ZERO;
      r_hi      <= ZERO;
      r_lo      <= w_a_mag;
      r_b       <= w_b_mag;
      r_neg     <= w_start_neg;
      r_sel     <= w_sel;
      r_tag_lat <= bus.iTag;
    end else if (w_done) begin
      r_cnt     <= CNT_ZERO;
    end else if (w_busy_mul) begin
      r_cnt     <= r_cnt + CNT_ONE;
      r_hi      <= w_mul_sum[XLEN:1];
      r_lo      <= {w_mul_sum[0], r_lo[XLEN-1:1]};
    end else if (w_busy_div) begin
      r_cnt     <= r_cnt + CNT_ONE;
      r_hi      <= w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0];
      r_lo      <= {r_lo[XLEN-2:0], w_div_ge};
    end else begin
      r_cnt     <= r_cnt;
    end
  end

  // Result registers: one-cycle strobe, result held between strobes
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_valid   <= 1'b0;
      r_result  <= ZERO;
      r_tag     <= 5'd0;
      r_illegal <= 1'b0;
    end else if (w_single) begin
      r_valid   <= 1'b1;
      r_result  <= w_single_res;
      r_tag     <= bus.iTag;
      r_illegal <= ~w_legal;
    end else if (w_done) begin
      r_valid   <= 1'b1;
      r_result  <= w_done_res;
      r_tag     <= r_tag_lat;
      r_illegal <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.oReady   = w_ready;
  assign bus.oValid   = r_valid;
  assign bus.oResult  = r_result;
  assign bus.oTag     = r_tag;
  assign bus.oIllegal = r_illegal;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed, table-driven bench for alu_muldiv (XLEN=32). Two instances:
// dut0 with all extensions, dut1 with MUL_EN=0.
module tb_alu_muldiv;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  // Edge offset (from the accept edge) at which the strobe is registered
  localparam logic [7:0] L1 = 8'd0;
  localparam logic [7:0] LM = 8'd33;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        ill;
    logic [7:0]  lat;
    logic        dut1;
    logic        poke;
  } vec_t;

  logic clk;
  logic rst;

  logic        sel;
  logic        drv_valid;
  logic [4:0]  drv_op;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic [4:0]  drv_tag;

  logic        obs_ready;
  logic        obs_valid;
  logic [31:0] obs_result;
  logic [4:0]  obs_tag;
  logic        obs_illegal;

  int n_checks;
  int n_errors;

  vec_t vecs[$];

  alu_muldiv_if #(.XLEN(32)) if0 ();
  alu_muldiv_if #(.XLEN(32)) if1 ();

  assign if0.iValid = drv_valid & ~sel;
  assign if0.iOp    = drv_op;
  assign if0.iOpA   = drv_a;
  assign if0.iOpB   = drv_b;
  assign if0.iTag   = drv_tag;
  assign if1.iValid = drv_valid & sel;
  assign if1.iOp    = drv_op;
  assign if1.iOpA   = drv_a;
  assign if1.iOpB   = drv_b;
  assign if1.iTag   = drv_tag;

  alu_muldiv #(.XLEN(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) u_dut0 (
    .iClk (clk),
    .iRst (rst),
    .bus  (if0)
  );

  alu_muldiv #(.XLEN(32), .MUL_EN(1'b0), .DIV_EN(1'b1)) u_dut1 (
    .iClk (clk),
    .iRst (rst),
    .bus  (if1)
  );

  // Observe whichever instance is currently selected
  always_comb begin
    if (sel) begin
      obs_ready   = if1.oReady;
      obs_valid   = if1.oValid;
      obs_result  = if1.oResult;
      obs_tag     = if1.oTag;
      obs_illegal = if1.oIllegal;
    end else begin
      obs_ready   = if0.oReady;
      obs_valid   = if0.oValid;
      obs_result  = if0.oResult;
      obs_tag     = if0.oTag;
      obs_illegal = if0.oIllegal;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] tag, input logic [31:0] res, input logic ill,
                              input logic [7:0] lat, input logic dut1, input logic poke);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.ill = ill;
    v.lat = lat; v.dut1 = dut1; v.poke = poke;
    return v;
  endfunction

  // Issue one op when ready, time its strobe, compare everything it returns
  task automatic run_op(input int idx, input vec_t v);
    int  n;
    logic ready_bad;
    sel = v.dut1;
    @(negedge clk);
    n = 0;
    while (obs_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_ready_in", idx), {63'd0, obs_ready}, 64'd1);
    drv_valid = 1'b1;
    drv_op    = v.op;
    drv_a     = v.a;
    drv_b     = v.b;
    drv_tag   = v.tag;
    @(negedge clk);
    drv_valid = 1'b0;
    n = 0;
    ready_bad = 1'b0;
    while (obs_valid !== 1'b1 && n < 100) begin
      if (obs_ready !== 1'b0) ready_bad = 1'b1;
      if (v.poke) begin
        drv_valid = ((n % 2) == 1);
        drv_op    = OP_ADD;
        drv_a     = 32'h0000_1111;
        drv_b     = 32'h0000_2222;
        drv_tag   = 5'd31;
      end
      @(negedge clk);
      n++;
    end
    drv_valid = 1'b0;
    check($sformatf("v%0d_strobe", idx), {63'd0, obs_valid}, 64'd1);
    check($sformatf("v%0d_lat", idx), 64'(n), 64'(v.lat));
    check($sformatf("v%0d_result", idx), {32'd0, obs_result}, {32'd0, v.res});
    check($sformatf("v%0d_tag", idx), {59'd0, obs_tag}, {59'd0, v.tag});
    check($sformatf("v%0d_illegal", idx), {63'd0, obs_illegal}, {63'd0, v.ill});
    if (v.lat != L1) begin
      check($sformatf("v%0d_busy_ready", idx), {63'd0, ready_bad}, 64'd0);
      check($sformatf("v%0d_ready_at_strobe", idx), {63'd0, obs_ready}, 64'd1);
    end
    @(negedge clk);
    check($sformatf("v%0d_one_pulse", idx), {63'd0, obs_valid}, 64'd0);
  endtask

  initial begin
    int spur;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_op    = 5'd0;
    drv_a     = 32'd0;
    drv_b     = 32'd0;
    drv_tag   = 5'd0;

    // op, a, b, tag, result, illegal, latency, dut1, poke
    vecs.push_back(mk(OP_SUB,    32'h0000_0005, 32'h0000_0007, 5'd1,  32'hFFFF_FFFE, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SLL,    32'h0000_0001, 32'h0000_003F, 5'd2,  32'h8000_0000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  32'h0000_0001, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SLTU,   32'hFFFF_FFFF, 32'h0000_0001, 5'd4,  32'h0000_0000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5,  32'h0FF0_0FF0, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SRL,    32'h8000_0000, 32'h0000_0024, 5'd6,  32'h0800_0000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SRA,    32'h7000_0000, 32'h0000_0004, 5'd7,  32'h0700_0000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_OR,     32'h1234_0000, 32'h0000_5678, 5'd8,  32'h1234_5678, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9,  32'hF000_F000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd14, 32'hFFFF_FFFD, 1'b0, LM, 1'b0, 1'b1));
    vecs.push_back(mk(OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd15, 32'hFFFF_FFFF, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_DIVU,   32'h0000_0064, 32'h0000_0007, 5'd16, 32'h0000_000E, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_REMU,   32'h0000_0064, 32'h0000_0007, 5'd17, 32'h0000_0002, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 5'd19, 32'h0000_0001, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(OP_DIVU,   32'h0000_0005, 32'h0000_0000, 5'd20, 32'hFFFF_FFFF, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_REM,    32'h0000_0005, 32'h0000_0000, 5'd21, 32'h0000_0005, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000, 1'b0, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h0000_0000, 1'b0, LM, 1'b0, 1'b0));
    vecs.push_back(mk(5'd10,     32'h1234_5678, 32'h0000_0001, 5'd25, 32'h0000_0000, 1'b1, L1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_MUL,    32'h0000_0003, 32'h0000_0004, 5'd26, 32'h0000_0000, 1'b1, L1, 1'b1, 1'b0));
    vecs.push_back(mk(5'd31,     32'h0000_0003, 32'h0000_0004, 5'd27, 32'h0000_0000, 1'b1, L1, 1'b1, 1'b0));
    vecs.push_back(mk(OP_DIVU,   32'h0000_0064, 32'h0000_0007, 5'd28, 32'h0000_000E, 1'b0, LM, 1'b1, 1'b0));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",   {63'd0, if0.oReady},   64'd1);
    check("rst_valid",   {63'd0, if0.oValid},   64'd0);
    check("rst_result",  {32'd0, if0.oResult},  64'd0);
    check("rst_tag",     {59'd0, if0.oTag},     64'd0);
    check("rst_illegal", {63'd0, if0.oIllegal}, 64'd0);
    rst = 1'b0;

    // Back-to-back single-cycle ops give back-to-back strobes
    sel = 1'b0;
    @(negedge clk);
    drv_valid = 1'b1; drv_op = OP_ADD; drv_a = 32'hFFFF_FFFF; drv_b = 32'h0000_0001; drv_tag = 5'd3;
    @(negedge clk);
    check("b2b0_valid",  {63'd0, obs_valid},  64'd1);
    check("b2b0_result", {32'd0, obs_result}, 64'h0000_0000);
    check("b2b0_tag",    {59'd0, obs_tag},    64'd3);
    drv_op = OP_SRA; drv_a = 32'h8000_0000; drv_b = 32'h0000_0004; drv_tag = 5'd4;
    @(negedge clk);
    drv_valid = 1'b0;
    check("b2b1_valid",  {63'd0, obs_valid},  64'd1);
    check("b2b1_result", {32'd0, obs_result}, 64'hF800_0000);
    check("b2b1_tag",    {59'd0, obs_tag},    64'd4);
    @(negedge clk);
    check("b2b_end_valid", {63'd0, obs_valid}, 64'd0);

    // Vector table
    foreach (vecs[i]) run_op(i, vecs[i]);

    // Reset 10 cycles into a DIVU aborts it with no strobe
    sel = 1'b0;
    @(negedge clk);
    drv_valid = 1'b1; drv_op = OP_DIVU; drv_a = 32'h1234_5678; drv_b = 32'h0000_0003; drv_tag = 5'd9;
    @(negedge clk);
    drv_valid = 1'b0;
    check("abort_busy", {63'd0, obs_ready}, 64'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready",   {63'd0, obs_ready},   64'd1);
    check("abort_valid",   {63'd0, obs_valid},   64'd0);
    check("abort_result",  {32'd0, obs_result},  64'd0);
    check("abort_tag",     {59'd0, obs_tag},     64'd0);
    check("abort_illegal", {63'd0, obs_illegal}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    spur = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (obs_valid === 1'b1) spur++;
    end
    check("abort_no_strobe", 64'(spur), 64'd0);
    run_op(100, mk(OP_ADD, 32'h0000_0002, 32'h0000_0003, 5'd7, 32'h0000_0005, 1'b0, L1, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU for the RISC-V core. It covers the RV32I/RV64I integer register-register operations in one cycle, plus the optional M-extension multiply, divide and remainder operations as iterative multi-cycle operations. It sits between decode/operand-fetch and writeback. It accepts one operation at a time on a valid/ready handshake and returns one tagged result pulse per accepted operation.

## Interface

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- MUL_EN, 1, 1 enables MUL/MULH/MULHSU/MULHU; 0 makes them illegal.
- DIV_EN, 1, 1 enables DIV/DIVU/REM/REMU; 0 makes them illegal.

Ports:
- iClk  in  1  sole clock; all state changes on the rising edge.
- iRst  in  1  reset; asynchronous, active-high.
- iValid  in  1  operation request.
- oReady  out  1  block can accept; a transfer occurs on an edge where iValid && oReady.
- iOp  in  5  operation code, encoded below.
- iOpA  in  XLEN  operand rs1.
- iOpB  in  XLEN  operand rs2.
- iTag  in  5  destination register index; returned unchanged with the result.
- oValid  out  1  single-cycle result strobe; no backpressure.
- oResult  out  XLEN  result; holds its value between strobes.
- oTag  out  5  tag of the operation being returned.
- oIllegal  out  1  qualifies oValid; set when iOp was unsupported.

## Operation

Opcode encoding:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU.
- 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Any other code is illegal. M-group codes are also illegal when their enable parameter is 0.

Arithmetic and width rules:
- Add/sub wrap modulo 2^XLEN.
- Shift amount is iOpB[log2(XLEN)-1:0]. SRA sign-extends.
- SLT/SLTU return 1 or 0, zero-extended.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH, MULHSU and MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Multiply: shift-add on operand magnitudes, one bit per cycle, sign fixup at completion.
- Divide: restoring division on magnitudes, one quotient bit per cycle, sign fixup at completion. Remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = dividend. No iteration is performed.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder = 0. No iteration is performed.
- Illegal op: oResult = 0, oIllegal = 1.

State machine (states IDLE, MUL, DIV):
- IDLE: oReady = 1.
- Accepting a single-cycle, illegal or special-case divide op stays in IDLE.
- Accepting a multiply goes to MUL; accepting a divide goes to DIV. oReady drops to 0 at that edge, and operands and tag are latched.
- MUL/DIV: a counter runs XLEN iterations, then returns to IDLE with a strobe. iValid is ignored while oReady = 0.

## Timing

- Reset (asserts immediately, independent of iClk):
  - state IDLE, counter 0, oReady = 1, oValid = 0, oResult = 0, oTag = 0, oIllegal = 0.
- Reset mid-operation aborts the operation. No strobe is produced for it.
- Single-cycle, illegal and special-case divide ops: accepted on edge k, oValid high for exactly the cycle after edge k. Back-to-back accepts give back-to-back strobes.
- Multi-cycle ops, accepted on edge k:
  - oReady low from edge k to edge k+XLEN+1.
  - oValid high for one cycle after edge k+XLEN+1.
  - oReady returns to 1 in that same cycle, so the next op can be accepted on edge k+XLEN+2.
- Every accepted op produces exactly one strobe. Results return in acceptance order. oTag and oIllegal are valid only while oValid = 1.

## Test plan

- After reset, issue ADD 0xFFFFFFFF + 1, then SRA 0x80000000 by 4 on consecutive edges (XLEN=32) -> strobes on consecutive cycles with results 0x00000000 and 0xF8000000, tags echoed.
- MULH 0x80000000 × 0x80000000 -> oReady low for 33 cycles, oValid 33 cycles after accept, result 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD; REM −7 / 2 -> 0xFFFFFFFF. Also check the latency of 33 cycles and that iValid pulses while busy are ignored.
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / −1 -> 0x80000000; REM of the same operands -> 0. All four strobe 1 cycle after accept.
- With MUL_EN=0, issue MUL, then opcode 31 -> oValid with oIllegal=1 and oResult=0, each 1 cycle after accept.
- Assert iRst 10 cycles into a DIVU -> all outputs return to reset values immediately and no strobe appears. A following ADD 2+3 returns 5 one cycle after accept.
